// File: rtl/build_info_axil.sv
// build_info_axil
//
// AXI4-Lite slave that exposes the 64-bit build identifier, the captured
// USR_ACCESSE2 (AXSS) word, a capture status word and a writable scratch
// register to the PS.
//
// Register map (byte offsets, decode on addr[ADDR_W-1:2]):
//   0x00  build_value_i[31:0]                  RO
//   0x04  build_value_i[63:32]                 RO
//   0x08  captured usr_word                    RO
//   0x0C  status {16'h0, count[7:0], 7'h0, usr_valid}  RO
//   0x10  scratch (byte strobes honoured)      RW
//   0x14  bitstream timestamp decode           RO (only with the macro below)
//   other rdata 0, SLVERR
//
// Optional feature macro: BUILD_INFO_TS_DECODE_EN
//   Defined   : 0x14 returns the usr_word timestamp repacked as
//               {1'b0, year[5:0], month[3:0], day[4:0], hour[4:0], min[5:0], 5'b0};
//               OKAY once a word has been captured, otherwise 0 with SLVERR.
//   Undefined : 0x14 behaves as an unmapped address and no decode logic exists.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   build_value_i            static 64-bit build identifier
//   usr_access_data_i        AXSS register contents
//   usr_access_datavalid_i   asynchronous DATAVALID, synchronised internally
//   s_axi_*                  AXI4-Lite slave (AW, W, B, AR, R channels)

module build_info_axil #(
  parameter int          ADDR_W      = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       build_value_i,
  input  logic [31:0]       usr_access_data_i,
  input  logic              usr_access_datavalid_i,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int         IDX_W       = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;

  rd_state_t              rd_state;
  wr_state_t              wr_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   sync_rise;
  logic [31:0]            usr_word;
  logic                   usr_valid;
  logic [7:0]             cap_count;
  logic [31:0]            scratch;
  logic [31:0]            status_word;
  logic [IDX_W-1:0]       rd_idx;
  logic [31:0]            rd_value;
  logic [1:0]             rd_resp;
  logic                   aw_held;
  logic                   w_held;
  logic [IDX_W-1:0]       wr_idx;
  logic [31:0]            w_data_q;
  logic [3:0]             w_strb_q;

  // Byte-lane bits of the addresses take no part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr[1:0], s_axi_awaddr[1:0]};

  // DATAVALID is asynchronous to clk, so it crosses through a plain flop
  // chain; the extra sync_prev flop gives a clean rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], usr_access_datavalid_i};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

  // Each synchronised rising edge captures the AXSS word; the last capture
  // wins, the valid flag is sticky and the count saturates at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      usr_word  <= '0;
      usr_valid <= 1'b0;
      cap_count <= '0;
    end else if (sync_rise) begin
      usr_word  <= usr_access_data_i;
      usr_valid <= 1'b1;
      if (cap_count != 8'hFF) cap_count <= cap_count + 8'd1;
    end
  end

  assign status_word = {16'h0000, cap_count, 7'h00, usr_valid};

`ifdef BUILD_INFO_TS_DECODE_EN
  // Repack the AXSS bitstream timestamp fields into a year-first layout.
  logic [31:0] ts_word;
  assign ts_word = {1'b0, usr_word[22:17], usr_word[26:23], usr_word[31:27],
                    usr_word[16:12], usr_word[11:6], 5'b00000};
`endif

  // Read decode: value and response for whatever address is on AR now.
  always_comb begin
    rd_idx   = s_axi_araddr[ADDR_W-1:2];
    rd_value = '0;
    rd_resp  = RESP_OKAY;
    case (rd_idx)
      IDX_W'(0): rd_value = build_value_i[31:0];
      IDX_W'(1): rd_value = build_value_i[63:32];
      IDX_W'(2): rd_value = usr_word;
      IDX_W'(3): rd_value = status_word;
      IDX_W'(4): rd_value = scratch;
`ifdef BUILD_INFO_TS_DECODE_EN
      IDX_W'(5): begin
        if (usr_valid) rd_value = ts_word;
        else           rd_resp  = RESP_SLVERR;
      end
`endif
      default:   rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel: accept one address, present the latched data until the
  // master takes it, then reopen AR on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state      <= RD_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rdata   <= rd_value;
            s_axi_rresp   <= rd_resp;
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            rd_state      <= RD_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write channel: AW and W are captured independently and held; the commit
  // happens on the cycle both are held, and B follows one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state      <= WR_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      wr_idx        <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      scratch       <= SCRATCH_RST;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_held && w_held) begin
            if (wr_idx == IDX_W'(4)) begin
              for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) scratch[8*b +: 8] <= w_data_q[8*b +: 8];
              end
              s_axi_bresp <= RESP_OKAY;
            end else begin
              s_axi_bresp <= RESP_SLVERR;
            end
            s_axi_bvalid <= 1'b1;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            wr_state     <= WR_RESP;
          end else begin
            if (!aw_held) begin
              if (s_axi_awvalid && s_axi_awready) begin
                wr_idx        <= s_axi_awaddr[ADDR_W-1:2];
                aw_held       <= 1'b1;
                s_axi_awready <= 1'b0;
              end else begin
                s_axi_awready <= 1'b1;
              end
            end
            if (!w_held) begin
              if (s_axi_wvalid && s_axi_wready) begin
                w_data_q     <= s_axi_wdata;
                w_strb_q     <= s_axi_wstrb;
                w_held       <= 1'b1;
                s_axi_wready <= 1'b0;
              end else begin
                s_axi_wready <= 1'b1;
              end
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule
